// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the EX-stage multiply/divide engine: op codes,
// FSM states and operand classification helpers.
package ex_muldiv_unit_pkg;

  localparam int INSTR_WIDTH = 32;
  localparam int MD_WIDTH    = INSTR_WIDTH;
  localparam int MD_CNT_W    = 5;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } md_state_e;

  function automatic logic is_md_op(input logic [2:0] op);
    logic res;
    case (op)
      MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Pipeline-side bundle of the multiply/divide engine: ID/EX operands and
// opcode, MTHI/MTLO writes, and stall/result/HI/LO back to the pipeline.
interface ex_muldiv_unit_if #(
  parameter int WIDTH = ex_muldiv_unit_pkg::MD_WIDTH
);
  logic [2:0]       op_i;
  logic [WIDTH-1:0] rs_data_i;
  logic [WIDTH-1:0] rt_data_i;
  logic             hold_i;
  logic             flush_i;
  logic             whi_i;
  logic             wlo_i;
  logic [WIDTH-1:0] wdata_i;
  logic             stall_o;
  logic             busy_o;
  logic             done_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;

  modport master (
    output op_i, rs_data_i, rt_data_i, hold_i, flush_i, whi_i, wlo_i, wdata_i,
    input  stall_o, busy_o, done_o, hi_o, lo_o
  );

  modport slave (
    input  op_i, rs_data_i, rt_data_i, hold_i, flush_i, whi_i, wlo_i, wdata_i,
    output stall_o, busy_o, done_o, hi_o, lo_o
  );
endinterface

// File: rtl/muldiv_datapath.sv
// Iterative datapath: radix-2 shift-add multiply and restoring divide on
// operand magnitudes, with sign fix-up applied to the final iteration's value.
module muldiv_datapath import ex_muldiv_unit_pkg::*; #(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo
);

  logic             signed_s, div_s, a_neg_s, b_neg_s;
  logic [WIDTH-1:0] a_mag_s, b_mag_s;
  logic [WIDTH-1:0] acc_hi_r, acc_lo_r, opd_r, raw_a_r;
  logic             div_r, neg_res_r, neg_rem_r, b_zero_r;
  logic [WIDTH:0]   mul_sum_s, div_shift_s, div_trial_s;
  logic [WIDTH-1:0] hi_nx_s, lo_nx_s;
  logic [2*WIDTH-1:0] prod_s;

  // Operand classification and magnitudes at issue
  always_comb begin
    signed_s = is_signed_op(op);
    div_s    = is_div_op(op);
    a_neg_s  = signed_s & opa[WIDTH-1];
    b_neg_s  = signed_s & opb[WIDTH-1];
    a_mag_s  = a_neg_s ? ({WIDTH{1'b0}} - opa) : opa;
    b_mag_s  = b_neg_s ? ({WIDTH{1'b0}} - opb) : opb;
  end

  // One iteration: {acc_hi, acc_lo} is the product/remainder-quotient pair
  always_comb begin
    mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opd_r} : {(WIDTH+1){1'b0}});
    div_shift_s = {acc_hi_r, acc_lo_r[WIDTH-1]};
    div_trial_s = div_shift_s - {1'b0, opd_r};
    if (div_r) begin
      if (!div_trial_s[WIDTH]) begin
        hi_nx_s = div_trial_s[WIDTH-1:0];
        lo_nx_s = {acc_lo_r[WIDTH-2:0], 1'b1};
      end else begin
        hi_nx_s = div_shift_s[WIDTH-1:0];
        lo_nx_s = {acc_lo_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      hi_nx_s = mul_sum_s[WIDTH:1];
      lo_nx_s = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
    end
  end

  // Sign fix-up; the top samples this only on the last iteration
  always_comb begin
    prod_s = {hi_nx_s, lo_nx_s};
    if (neg_res_r) begin
      prod_s = {(2*WIDTH){1'b0}} - prod_s;
    end else begin
      prod_s = {hi_nx_s, lo_nx_s};
    end
    if (!div_r) begin
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end else if (b_zero_r) begin
      res_hi = raw_a_r;
      res_lo = {WIDTH{1'b1}};
    end else begin
      res_hi = neg_rem_r ? ({WIDTH{1'b0}} - hi_nx_s) : hi_nx_s;
      res_lo = neg_res_r ? ({WIDTH{1'b0}} - lo_nx_s) : lo_nx_s;
    end
  end

  // Operand latch at issue, then accumulator update per CALC cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_hi_r  <= {WIDTH{1'b0}};
      acc_lo_r  <= {WIDTH{1'b0}};
      opd_r     <= {WIDTH{1'b0}};
      raw_a_r   <= {WIDTH{1'b0}};
      div_r     <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      b_zero_r  <= 1'b0;
    end else if (load) begin
      acc_hi_r  <= {WIDTH{1'b0}};
      acc_lo_r  <= div_s ? a_mag_s : b_mag_s;
      opd_r     <= div_s ? b_mag_s : a_mag_s;
      raw_a_r   <= opa;
      div_r     <= div_s;
      neg_res_r <= a_neg_s ^ b_neg_s;
      neg_rem_r <= a_neg_s;
      b_zero_r  <= (opb == {WIDTH{1'b0}});
    end else if (step) begin
      acc_hi_r  <= hi_nx_s;
      acc_lo_r  <= lo_nx_s;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// EX-stage multiply/divide unit: issue/iterate/done FSM, pipeline stall,
// and the architectural HI/LO registers with MTHI/MTLO writes.
module ex_muldiv_unit import ex_muldiv_unit_pkg::*; #(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = MD_CNT_W
) (
  input logic             clk,
  input logic             rst,
  ex_muldiv_unit_if.slave bus
);

  md_state_e        state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] hi_r, lo_r;
  logic [WIDTH-1:0] res_hi_s, res_lo_s;
  logic             start_s, calc_s, commit_s;

  // Issue and final-iteration detection; reset masks a pending issue
  always_comb begin
    calc_s   = (state_r == CALC);
    start_s  = ~rst & (state_r == IDLE) & is_md_op(bus.op_i) & ~bus.flush_i;
    commit_s = calc_s & ~bus.flush_i & (cnt_r == CNT_W'(WIDTH-1));
  end

  // Next-state logic
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_nx_s = CALC;
        else         state_nx_s = IDLE;
      end
      CALC: begin
        if (bus.flush_i) state_nx_s = IDLE;
        else if (commit_s) state_nx_s = DONE;
        else             state_nx_s = CALC;
      end
      DONE: begin
        // Holding in DONE keeps the still-present op from re-issuing
        if (bus.hold_i) state_nx_s = DONE;
        else            state_nx_s = IDLE;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nx_s;
  end

  // Iteration counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt_r <= {CNT_W{1'b0}};
    else if (start_s) cnt_r <= {CNT_W{1'b0}};
    else if (calc_s)  cnt_r <= cnt_r + CNT_W'(1);
    else              cnt_r <= {CNT_W{1'b0}};
  end

  // HI/LO: result commit wins; MTHI/MTLO only land while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_r <= {WIDTH{1'b0}};
      lo_r <= {WIDTH{1'b0}};
    end else if (commit_s) begin
      hi_r <= res_hi_s;
      lo_r <= res_lo_s;
    end else if (state_r == IDLE) begin
      if (bus.whi_i) hi_r <= bus.wdata_i;
      if (bus.wlo_i) lo_r <= bus.wdata_i;
    end
  end

  muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (start_s),
    .step   (calc_s),
    .op     (bus.op_i),
    .opa    (bus.rs_data_i),
    .opb    (bus.rt_data_i),
    .res_hi (res_hi_s),
    .res_lo (res_lo_s)
  );

  assign bus.stall_o = start_s | (calc_s & ~bus.flush_i);
  assign bus.busy_o  = calc_s;
  assign bus.done_o  = (state_r == DONE);
  assign bus.hi_o    = hi_r;
  assign bus.lo_o    = lo_r;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors, random ops
// against an arithmetic reference, and flush/hold/reset sequences.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  localparam int W = 32;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[9];

  ex_muldiv_unit_if #(.WIDTH(W)) bus ();
  ex_muldiv_unit #(.WIDTH(W), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, MIPS semantics for divide by zero
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up, uq, ur;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      3'd1: begin sp = sa * sb; return sp; end
      3'd2: begin up = ua * ub; return up; end
      3'd3: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      3'd4: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'h0;
    endcase
  endfunction

  // Waits (bounded) for done_o, counting stall cycles from the issue cycle
  task automatic wait_done(output int n, output bit seen);
    n = 0;
    seen = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (bus.done_o) begin
        seen = 1'b1;
        break;
      end
      if (bus.stall_o) n++;
      @(negedge clk);
    end
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] exp, input string name);
    int n;
    bit seen;
    @(negedge clk);
    bus.op_i = op;
    bus.rs_data_i = a;
    bus.rt_data_i = b;
    wait_done(n, seen);
    check({name, " done"}, 64'(seen), 64'd1);
    check({name, " stall_cycles"}, 64'(n), 64'd33);
    check({name, " hi"}, 64'(bus.hi_o), 64'(exp[63:32]));
    check({name, " lo"}, 64'(bus.lo_o), 64'(exp[31:0]));
    check({name, " stall_in_done"}, 64'(bus.stall_o), 64'd0);
    bus.op_i = MD_NONE;
    @(negedge clk);
    #1;
    check({name, " done_pulse"}, 64'(bus.done_o), 64'd0);
    check({name, " busy_after"}, 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    int n, extra;
    bit seen;
    logic [2:0] rop;
    logic [31:0] ra, rb;

    vecs[0] = '{3'd1, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult_neg"};
    vecs[1] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max"};
    vecs[2] = '{3'd3, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg"};
    vecs[3] = '{3'd4, 32'd100,       32'd7,         32'd2,         32'd14,        "divu"};
    vecs[4] = '{3'd3, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF, "div_zero"};
    vecs[5] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, "div_ovf"};
    vecs[6] = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,         "mult_minmin"};
    vecs[7] = '{3'd3, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, "div_negdivisor"};
    vecs[8] = '{3'd4, 32'hFFFF_FFF8, 32'h0,         32'hFFFF_FFF8, 32'hFFFF_FFFF, "divu_zero"};

    rst = 1'b1;
    bus.op_i = MD_NONE;
    bus.rs_data_i = 32'h0;
    bus.rt_data_i = 32'h0;
    bus.hold_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.whi_i = 1'b0;
    bus.wlo_i = 1'b0;
    bus.wdata_i = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("reset hi", 64'(bus.hi_o), 64'd0);
    check("reset lo", 64'(bus.lo_o), 64'd0);
    check("reset stall", 64'(bus.stall_o), 64'd0);
    check("reset busy", 64'(bus.busy_o), 64'd0);
    check("reset done", 64'(bus.done_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo}, vecs[i].name);
    end

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'h0 :
            ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 1000));
      run_op(rop, ra, rb, ref_md(rop, ra, rb), "random");
    end

    // MTHI/MTLO preload, then flush an in-flight MULT
    @(negedge clk);
    bus.whi_i = 1'b1;
    bus.wdata_i = 32'hAAAA_0000;
    @(negedge clk);
    bus.whi_i = 1'b0;
    bus.wlo_i = 1'b1;
    bus.wdata_i = 32'h0000_5555;
    @(negedge clk);
    bus.wlo_i = 1'b0;
    #1;
    check("mthi hi", 64'(bus.hi_o), 64'h0000_0000_AAAA_0000);
    check("mtlo lo", 64'(bus.lo_o), 64'h0000_0000_0000_5555);
    bus.op_i = MD_MULT;
    bus.rs_data_i = 32'd9;
    bus.rt_data_i = 32'd9;
    repeat (10) @(negedge clk);
    bus.flush_i = 1'b1;
    bus.op_i = MD_NONE;
    #1;
    check("flush stall_same_cycle", 64'(bus.stall_o), 64'd0);
    check("flush busy_before_edge", 64'(bus.busy_o), 64'd1);
    @(negedge clk);
    bus.flush_i = 1'b0;
    #1;
    check("flush busy", 64'(bus.busy_o), 64'd0);
    check("flush stall", 64'(bus.stall_o), 64'd0);
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.done_o || bus.busy_o) extra++;
    end
    check("flush no_result", 64'(extra), 64'd0);
    check("flush hi_kept", 64'(bus.hi_o), 64'h0000_0000_AAAA_0000);
    check("flush lo_kept", 64'(bus.lo_o), 64'h0000_0000_0000_5555);

    // Flush in IDLE suppresses issue
    @(negedge clk);
    bus.op_i = MD_DIVU;
    bus.flush_i = 1'b1;
    #1;
    check("idle_flush stall", 64'(bus.stall_o), 64'd0);
    @(negedge clk);
    #1;
    check("idle_flush busy", 64'(bus.busy_o), 64'd0);
    bus.op_i = MD_NONE;
    bus.flush_i = 1'b0;

    // Hold in DONE with op still MULT: no re-issue, one result
    @(negedge clk);
    bus.op_i = MD_MULT;
    bus.rs_data_i = 32'd5;
    bus.rt_data_i = 32'd6;
    wait_done(n, seen);
    check("hold done", 64'(seen), 64'd1);
    check("hold lo", 64'(bus.lo_o), 64'd30);
    bus.hold_i = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      check("hold still_done", 64'(bus.done_o), 64'd1);
      check("hold no_stall", 64'(bus.stall_o), 64'd0);
      check("hold no_busy", 64'(bus.busy_o), 64'd0);
    end
    bus.hold_i = 1'b0;
    bus.op_i = MD_NONE;
    extra = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (bus.done_o || bus.busy_o) extra++;
    end
    check("hold no_reissue", 64'(extra), 64'd0);
    check("hold hi", 64'(bus.hi_o), 64'd0);

    // Async reset in the middle of CALC
    @(negedge clk);
    bus.op_i = MD_MULT;
    bus.rs_data_i = 32'h1234_5678;
    bus.rt_data_i = 32'h0000_0100;
    repeat (6) @(negedge clk);
    #1;
    check("midcalc busy", 64'(bus.busy_o), 64'd1);
    rst = 1'b1;
    #1;
    check("rst hi", 64'(bus.hi_o), 64'd0);
    check("rst lo", 64'(bus.lo_o), 64'd0);
    check("rst stall", 64'(bus.stall_o), 64'd0);
    check("rst busy", 64'(bus.busy_o), 64'd0);
    check("rst done", 64'(bus.done_o), 64'd0);
    bus.op_i = MD_NONE;
    @(negedge clk);
    rst = 1'b0;

    // Back-to-back after reset still produces correct results
    run_op(3'd4, 32'd1000, 32'd33, ref_md(3'd4, 32'd1000, 32'd33), "post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
